// File: rtl/mdio_slave_mp.sv
// mdio_slave_mp -- multi-address MDIO (Clause 22) management slave.
//
// Answers PHY addresses PHY_BASE .. PHY_BASE+N_PHY-1. Reads are forwarded
// through a level request / ack port; writes come out as a one-clk strobe.
// MDC and MDIO are synchronised into the clk domain, and every action is
// taken on a detected MDC rising edge.
//
// Optional feature: define MDIO_PREAMBLE_SUPPRESS_EN to allow a frame to
// follow a completed frame without a preamble. The frame then starts from
// the IDLE state.
//
// Ports:
//   clk, rst            fabric clock, async active-high reset
//   mdc_i, mdio_i       MDIO pins (asynchronous)
//   mdio_o, mdio_oe     MDIO drive value / output enable to the pad buffer
//   rd_req/rd_phy/rd_reg, rd_ack/rd_data   read handshake
//   wr_en/wr_phy/wr_reg/wr_data            write strobe
//   frame_err           one-clk pulse: malformed header or read timeout
//   busy                a frame is being received or answered
module mdio_slave_mp #(
    parameter int PHY_BASE    = 0,
    parameter int N_PHY       = 1,
    parameter int PRE_LEN     = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mdc_i,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_oe,
    output logic        rd_req,
    output logic [4:0]  rd_phy,
    output logic [4:0]  rd_reg,
    input  logic        rd_ack,
    input  logic [15:0] rd_data,
    output logic        wr_en,
    output logic [4:0]  wr_phy,
    output logic [4:0]  wr_reg,
    output logic [15:0] wr_data,
    output logic        frame_err,
    output logic        busy
);

    typedef enum logic [2:0] {
        PRE,
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
        IDLE,
`endif
        HDR,
        TA_RD,
        RD_DATA,
        TA_WR,
        WR_DATA,
        SKIP
    } state_t;

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    localparam state_t END_ST = IDLE;
`else
    localparam state_t END_ST = PRE;
`endif

    localparam logic [5:0] PRE_MIN  = 6'(PRE_LEN);
    localparam int         PHY_LAST = PHY_BASE + N_PHY - 1;

    // ---------------- synchronisers and edge detect ----------------
    logic [SYNC_STAGES-1:0] mdc_sync, mdio_sync;
    logic                   mdc_d;
    logic                   mdc_rise;   // registered: one clk per MDC rising edge
    logic                   mdio_bit;   // MDIO value aligned with mdc_rise

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mdc_sync  <= '0;
            mdio_sync <= '0;
            mdc_d     <= 1'b0;
            mdc_rise  <= 1'b0;
            mdio_bit  <= 1'b0;
        end else begin
            mdc_sync  <= {mdc_sync[SYNC_STAGES-2:0], mdc_i};
            mdio_sync <= {mdio_sync[SYNC_STAGES-2:0], mdio_i};
            mdc_d     <= mdc_sync[SYNC_STAGES-1];
            mdc_rise  <= mdc_sync[SYNC_STAGES-1] & ~mdc_d;
            mdio_bit  <= mdio_sync[SYNC_STAGES-1];
        end
    end

    // ---------------- frame FSM ----------------
    state_t      state;
    logic [5:0]  pre_cnt;
    logic [4:0]  bit_cnt;
    logic [15:0] sr;        // header / write-data shifter
    logic [15:0] rd_buf;    // read data, shifted out MSB first
    logic [4:0]  phy_lat, reg_lat;
    logic        rd_fail;   // this frame already raised frame_err (timeout)

    // Full header including the bit sampled on the current edge.
    logic [13:0] hdr;
    int          hdr_phy;
    logic        in_range;
    assign hdr      = {sr[12:0], mdio_bit};
    assign hdr_phy  = {27'd0, hdr[9:5]};
    assign in_range = (hdr_phy >= PHY_BASE) && (hdr_phy <= PHY_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= PRE;
            pre_cnt   <= '0;
            bit_cnt   <= '0;
            sr        <= '0;
            rd_buf    <= '0;
            phy_lat   <= '0;
            reg_lat   <= '0;
            rd_fail   <= 1'b0;
            mdio_o    <= 1'b0;
            mdio_oe   <= 1'b0;
            rd_req    <= 1'b0;
            rd_phy    <= '0;
            rd_reg    <= '0;
            wr_en     <= 1'b0;
            wr_phy    <= '0;
            wr_reg    <= '0;
            wr_data   <= '0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            wr_en     <= 1'b0;
            frame_err <= 1'b0;

            // Read handshake runs every clk, independent of MDC.
            if (rd_req && rd_ack) begin
                rd_buf <= rd_data;
                rd_req <= 1'b0;
            end

            if (mdc_rise) begin
                case (state)
                    PRE: begin
                        if (mdio_bit) begin
                            if (pre_cnt != '1) pre_cnt <= pre_cnt + 6'd1;
                        end else if (pre_cnt >= PRE_MIN) begin
                            // this zero is ST[1]
                            state   <= HDR;
                            busy    <= 1'b1;
                            pre_cnt <= '0;
                            bit_cnt <= 5'd1;
                            sr      <= '0;
                        end else begin
                            pre_cnt <= '0;
                        end
                    end
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
                    IDLE: begin
                        if (!mdio_bit) begin
                            state   <= HDR;
                            busy    <= 1'b1;
                            bit_cnt <= 5'd1;
                            sr      <= '0;
                        end
                    end
`endif
                    HDR: begin
                        sr      <= {sr[14:0], mdio_bit};
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd13) begin
                            bit_cnt <= '0;
                            rd_fail <= 1'b0;
                            phy_lat <= hdr[9:5];
                            reg_lat <= hdr[4:0];
                            if (hdr[13:12] != 2'b01 || hdr[11:10] == 2'b00 ||
                                hdr[11:10] == 2'b11) begin
                                frame_err <= 1'b1;
                                state     <= PRE;
                                pre_cnt   <= '0;
                                busy      <= 1'b0;
                            end else if (!in_range) begin
                                state <= SKIP;
                            end else if (hdr[11:10] == 2'b10) begin
                                state  <= TA_RD;
                                rd_req <= 1'b1;
                                rd_phy <= hdr[9:5];
                                rd_reg <= hdr[4:0];
                            end else begin
                                state <= TA_WR;
                            end
                        end
                    end
                    TA_RD: begin
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd1) begin
                            mdio_oe <= 1'b1;
                            mdio_o  <= 1'b0;
                            state   <= RD_DATA;
                            bit_cnt <= '0;
                            // An ack in this same clk is taken by the handshake above.
                            if (rd_req && !rd_ack) begin
                                rd_req    <= 1'b0;
                                frame_err <= 1'b1;
                                rd_buf    <= 16'hFFFF;
                                rd_fail   <= 1'b1;
                            end
                        end
                    end
                    RD_DATA: begin
                        if (bit_cnt == 5'd16) begin
                            mdio_oe <= 1'b0;
                            mdio_o  <= 1'b0;
                            busy    <= 1'b0;
                            bit_cnt <= '0;
                            pre_cnt <= '0;
                            // after an error a full preamble is required again
                            state   <= rd_fail ? PRE : END_ST;
                        end else begin
                            mdio_o  <= rd_buf[15];
                            rd_buf  <= {rd_buf[14:0], 1'b0};
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                    TA_WR: begin
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd1) begin
                            state   <= WR_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    WR_DATA: begin
                        sr      <= {sr[14:0], mdio_bit};
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd15) begin
                            wr_en   <= 1'b1;
                            wr_data <= {sr[14:0], mdio_bit};
                            wr_phy  <= phy_lat;
                            wr_reg  <= reg_lat;
                            state   <= END_ST;
                            busy    <= 1'b0;
                            bit_cnt <= '0;
                            pre_cnt <= '0;
                        end
                    end
                    SKIP: begin
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd17) begin
                            state   <= END_ST;
                            busy    <= 1'b0;
                            bit_cnt <= '0;
                            pre_cnt <= '0;
                        end
                    end
                    default: begin
                        state   <= PRE;
                        busy    <= 1'b0;
                        pre_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/mdio_slave_mp.md
# mdio_slave_mp

Multi-address MDIO (IEEE 802.3 Clause 22) management slave. It answers a configurable contiguous range of PHY addresses and exposes a request/acknowledge read port and a single-pulse write port to the register file behind it. It enforces the preamble, reports malformed frames, and synchronises the MDIO pins into the fabric clock domain. It sits between the board MDIO pins (via a tristate buffer) and one or more per-PHY register banks.

## Interface
- PHY_BASE, 0: first PHY address answered.
- N_PHY, 1: number of consecutive addresses answered; PHY_BASE+N_PHY ≤ 32.
- PRE_LEN, 32: consecutive ones required as preamble (1..63).
- SYNC_STAGES, 2: synchroniser depth on mdc_i/mdio_i (≥2).

- clk  in  1  fabric clock
- rst  in  1  asynchronous active-high reset
- mdc_i  in  1  MDC pin
- mdio_i  in  1  MDIO pin input
- mdio_o  out  1  MDIO drive value
- mdio_oe  out  1  MDIO output enable
- rd_req  out  1  read request (level, held until acked)
- rd_phy  out  5  PHY address of the read
- rd_reg  out  5  register address of the read
- rd_ack  in  1  read acknowledge; rd_data is valid with it
- rd_data  in  16  read data
- wr_en  out  1  one-clk write strobe
- wr_phy  out  5  PHY address of the write
- wr_reg  out  5  register address of the write
- wr_data  out  16  write data
- frame_err  out  1  one-clk pulse on a malformed frame or a read timeout
- busy  out  1  a frame is in progress

## Operation
- mdc_i and mdio_i each pass through SYNC_STAGES flops. An MDC rising edge ("edge") is detected on the synchronised MDC. The synchronised mdio_i is sampled on that edge.
- Reset values: mdio_oe=0, mdio_o=0, rd_req=0, wr_en=0, frame_err=0, busy=0; rd_phy, rd_reg, wr_phy, wr_reg, wr_data all 0. State is PRE and the ones counter is 0.
- PRE: a saturating counter counts consecutive sampled ones.
  - A zero with count < PRE_LEN clears the counter.
  - A zero with count ≥ PRE_LEN is taken as ST[1] and moves the FSM to HDR.
- IDLE: entered only when MDIO_PREAMBLE_SUPPRESS_EN is defined. A sampled zero moves the FSM to HDR; ones are ignored.
- HDR: shifts in 13 more bits, giving the 14-bit header ST, OP, PHYAD, REGAD. It decodes on the 14th edge:
  - ST≠01, or OP=00/11: frame_err pulse, go to PRE.
  - PHYAD outside [PHY_BASE, PHY_BASE+N_PHY-1]: go to SKIP, no error.
  - OP=10: go to TA_RD. Latch rd_phy and rd_reg, and set rd_req.
  - OP=01: go to TA_WR.
- TA_RD: on TA edge 1, mdio_oe stays 0. On TA edge 2, mdio_oe=1, mdio_o=0, then go to RD_DATA.
- Read handshake:
  - rd_data is captured and rd_req cleared in the clk where rd_req=1 and rd_ack=1.
  - rd_ack while rd_req=0 is ignored.
  - If no ack has arrived by TA edge 2 (an ack in that same clk counts), the slave clears rd_req, pulses frame_err and loads 16'hFFFF as data. A later ack is ignored.
- RD_DATA: 16 edges, each driving the next bit MSB first on mdio_o. On the 17th edge mdio_oe=0 and the FSM goes to the end state.
- TA_WR: 2 edges; sampled values are ignored.
- WR_DATA: shifts in 16 bits MSB first. After the 16th edge, wr_en pulses for one clk with wr_phy, wr_reg and wr_data, then the FSM goes to the end state.
- SKIP: counts 18 edges (TA plus data) with mdio_oe=0, then goes to the end state.
- End state: IDLE if MDIO_PREAMBLE_SUPPRESS_EN is defined, otherwise PRE with the counter cleared.
- busy=1 in HDR, TA_RD, RD_DATA, TA_WR, WR_DATA and SKIP.
- Reset mid-frame immediately forces mdio_oe=0 and drops rd_req. Any partial write is discarded.

## Timing
- The pin-to-edge-detect latency is SYNC_STAGES+1 clk. mdio_o/mdio_oe update in the clk after edge detection.
- MDC high and low phases must each be ≥ SYNC_STAGES+2 clk.
- rd_req rises 1 clk after the 14th-edge detection. The ack window runs from there to TA edge 2, i.e. 2 MDC periods.
- wr_en rises 1 clk after the 16th data-edge detection.
- frame_err rises 1 clk after the detecting edge.

## Configuration
- MDIO_PREAMBLE_SUPPRESS_EN defined: after a completed frame (read, write or skipped), the next frame may start without preamble (IDLE state). After reset or frame_err, a full PRE_LEN preamble is still required.
- Not defined: every frame requires PRE_LEN ones; the IDLE state is not built.

## Test plan
- PHY_BASE=4, N_PHY=2. 32 ones + write PHY 5, reg 3, data 16'hA55A -> one wr_en pulse with wr_phy=5, wr_reg=3, wr_data=16'hA55A.
- 32 ones + read PHY 4, reg 7; rd_ack after 3 clk with 16'h1234 -> mdio_oe=0 at TA1; TA2 drives 0; then bits of 16'h1234 MSB first; mdio_oe=0 after the 16th bit.
- Read PHY 4 with rd_ack never asserted -> frame_err pulse at TA2; 16'hFFFF driven; rd_req low thereafter.
- Read PHY 9 (out of range) -> mdio_oe stays 0, no rd_req, no frame_err, busy high for 32 edges after the preamble (14 header + 18 skipped).
- 31 ones then a frame -> ignored. Header ST=00 after a valid preamble -> frame_err pulse. Back-to-back frames without preamble -> accepted only with MDIO_PREAMBLE_SUPPRESS_EN.
- Assert rst during WR_DATA bit 8 -> no wr_en. The next valid preambled write completes normally.
